// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: two-master / one-slave data-memory arbiter (core priority, starvation slot, m1 lock)
// Rev 1.0
`default_nettype none

module ram_bus_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_gnt_o,
    output logic [DW-1:0] m0_rdata_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic          m1_lock_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_gnt_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_waddr_o,
    output logic [DW-1:0] ram_wdata_o,
    output logic [AW-1:0] ram_raddr_o,
    input  logic [DW-1:0] ram_rdata_i
);

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    typedef enum logic [0:0] {
        S_CORE   = 1'b0,
        S_M1LOCK = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_nxt;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // In lock, a present m1 request always wins; without it the cycle is arbitrated as in S_CORE.
    always_comb begin
        w_gnt1 = 1'b0;
        w_gnt0 = 1'b0;
        if (m1_req_i && ((r_state == S_M1LOCK) || (r_wait_cnt == C_STARVE_MAX) || !m0_req_i)) begin
            w_gnt1 = 1'b1;
        end else if (m0_req_i) begin
            w_gnt0 = 1'b1;
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_addr  = m0_addr_i;
        w_wdata = m0_wdata_i;
        if (w_gnt1) begin
            w_we    = m1_we_i;
            w_addr  = m1_addr_i;
            w_wdata = m1_wdata_i;
        end else if (w_gnt0) begin
            w_we    = m0_we_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        if (!m1_req_i || w_gnt1) begin
            w_wait_nxt = 4'd0;
        end else if (r_wait_cnt < C_STARVE_MAX) begin
            w_wait_nxt = r_wait_cnt + 4'd1;
        end
        if (w_gnt1) begin
            w_state_nxt = m1_lock_i ? S_M1LOCK : S_CORE;
        end else if (!m1_req_i) begin
            w_state_nxt = S_CORE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CORE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Outputs are gated by rst_n so an asserted reset kills a pending write beat without a clock edge.
    assign m0_gnt_o    = rst_n & w_gnt0;
    assign m1_gnt_o    = rst_n & w_gnt1;
    assign ram_we_o    = rst_n & w_we;
    assign ram_waddr_o = rst_n ? w_addr  : '0;
    assign ram_raddr_o = rst_n ? w_addr  : '0;
    assign ram_wdata_o = rst_n ? w_wdata : '0;
    assign m0_rdata_o  = rst_n ? ram_rdata_i : '0;
    assign m1_rdata_o  = rst_n ? ram_rdata_i : '0;

endmodule

`default_nettype wire
